// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the request arbiters.
// Pure definitions: no latency, no flow control.
package arb_pkg;

  localparam int N_REQ        = 4;
  localparam int IDX_W        = 2;
  localparam int TIMEOUT_DFLT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_prio_enc.sv
// Rotated 4-to-2 priority encoder: first set bit of req searching ptr, ptr+1, ... mod 4.
// Combinational, zero latency; no flow control (idx valid only when any=1).
module rr_prio_enc
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  // Walk from the farthest offset down so the nearest set bit to ptr is written last.
  always_comb begin
    idx = '0;
    pos = '0;
    any = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = ptr + IDX_W'(k);
      if (req[pos]) begin
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/req_arbiter_4.sv
// Round-robin 4-way arbiter, 1-cycle req-to-gnt, grant held until done; ARB_TIMEOUT_EN adds forced release.
// Holds one owner at a time; new requests wait for the IDLE cycle that follows every release.
module req_arbiter_4
  import arb_pkg::*;
#(
`ifdef ARB_TIMEOUT_EN
  parameter int TIMEOUT = TIMEOUT_DFLT
`endif
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;

  rr_prio_enc u_enc (
    .req (req),
    .ptr (ptr),
    .idx (win_idx),
    .any (win_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] hold_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      ptr      <= '0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (win_any) begin
            gnt      <= N_REQ'(1) << win_idx;
            gnt_idx  <= win_idx;
            gnt_vld  <= 1'b1;
            hold_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // done wins over an expiring counter, so a coincident release is not flagged.
          if (done || hold_cnt == HOLD_LAST) begin
            gnt     <= '0;
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx + 1'b1;
            timeout <= ~done;
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            gnt     <= N_REQ'(1) << win_idx;
            gnt_idx <= win_idx;
            gnt_vld <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            gnt     <= '0;
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx + 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
